// File: rtl/param_stream_pkg.sv
// Shared types and helpers for parameter-ROM streaming blocks.
package param_stream_pkg;

  // Sequencer states: idle, issuing ROM reads, waiting for the pipeline and FIFO to empty.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  // Tag carried alongside each in-flight ROM read.
  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

  // A read may be issued only while every word already owed to the FIFO
  // (stored or still in the ROM pipeline) leaves at least one free slot.
  function automatic logic has_credit(input int unsigned fifo_count,
                                      input int unsigned inflight_count,
                                      input int unsigned fifo_depth);
    return (fifo_count + inflight_count) < fifo_depth;
  endfunction

endpackage

// File: rtl/param_stream_fifo.sv
// Synchronous FIFO with occupancy count; head word is presented combinationally.
module param_stream_fifo #(
  parameter  int WIDTH = 513,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;

  assign w_pop   = i_pop && (r_count != '0);
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_count = r_count;
  // Empty FIFO presents zero so the stream output has a defined reset value.
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

  // Storage write.
  // NOTE: the data array has no reset; occupancy is tracked by the pointers, so clearing it buys nothing.
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy update; simultaneous push and pop leaves the count unchanged.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/param_rom_stream_ctrl.sv
// Streams a fixed-latency parameter ROM as a valid/ready word stream, replaying
// the whole tensor a programmable number of passes per start command.
module param_rom_stream_ctrl
  import param_stream_pkg::*;
#(
  parameter int DATA_WIDTH  = 512,
  parameter int DEPTH       = 32,
  parameter int ADDR_WIDTH  = $clog2(DEPTH) + 1,
  parameter int ROM_LATENCY = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int PASS_WIDTH  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [PASS_WIDTH-1:0] i_cfg_passes,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] o_rom_addr,
  output logic                  o_rom_ce,
  input  logic [DATA_WIDTH-1:0] i_rom_q,
  output logic [DATA_WIDTH-1:0] o_data_out,
  output logic                  o_data_out_last,
  output logic                  o_data_out_valid,
  input  logic                  i_data_out_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [PASS_WIDTH-1:0]   r_pass;
  logic [PASS_WIDTH-1:0]   r_passes;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_rom_ce;
  tag_t                    r_tags [ROM_LATENCY];

  logic                    w_issue;
  logic [CNT_W-1:0]        w_inflight;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_fifo_empty;
  logic                    w_fifo_full;
  logic [CNT_W-1:0]        w_fifo_count;
  logic [DATA_WIDTH:0]     w_fifo_head;
  logic                    w_fifo_drains;

  assign o_rom_addr       = r_addr;
  assign o_rom_ce         = r_rom_ce;
  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_data_out       = w_fifo_head[DATA_WIDTH-1:0];
  assign o_data_out_last  = w_fifo_head[DATA_WIDTH];
  assign o_data_out_valid = !w_fifo_empty;

  assign w_pop   = !w_fifo_empty && i_data_out_ready;
  assign w_push  = r_tags[ROM_LATENCY-1].valid;
  assign w_issue = (r_state == S_STREAM) &&
                   has_credit(32'(w_fifo_count), 32'(w_inflight), FIFO_DEPTH);
  // FIFO is empty now, or its last word leaves on this edge.
  assign w_fifo_drains = w_fifo_empty || ((w_fifo_count == CNT_W'(1)) && w_pop);

  // Count reads still travelling through the ROM pipeline.
  // NOTE: combinational outputs get a default before any conditional update so no latch is inferred.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < ROM_LATENCY; i++) begin
      w_inflight = w_inflight + CNT_W'(r_tags[i].valid);
    end
  end

  // Tag pipeline shadows the ROM pipeline and only advances while the ROM is enabled.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < ROM_LATENCY; i++) r_tags[i] <= '0;
    end else if (r_rom_ce) begin
      r_tags[0] <= '{valid: w_issue, last: w_issue && (r_addr == LAST_ADDR)};
      for (int i = 1; i < ROM_LATENCY; i++) r_tags[i] <= r_tags[i-1];
    end
  end

  // Command sequencer: address/pass counters, state and registered status outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_pass   <= '0;
      r_passes <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_rom_ce <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (i_cfg_passes != '0) begin
              r_state  <= S_STREAM;
              r_passes <= i_cfg_passes;
              r_pass   <= '0;
              r_addr   <= '0;
              r_busy   <= 1'b1;
              r_rom_ce <= 1'b1;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_STREAM: begin
          if (w_issue) begin
            if (r_addr == LAST_ADDR) begin
              r_addr <= '0;
              r_pass <= r_pass + PASS_WIDTH'(1);
              if (r_pass == r_passes - PASS_WIDTH'(1)) r_state <= S_DRAIN;
            end else begin
              r_addr <= r_addr + ADDR_WIDTH'(1);
            end
          end
        end
        S_DRAIN: begin
          if ((w_inflight == '0) && w_fifo_drains) begin
            r_state  <= S_IDLE;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_rom_ce <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  param_stream_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_data  ({r_tags[ROM_LATENCY-1].last, i_rom_q}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_head),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full),
    .o_count (w_fifo_count)
  );

  // The credit rule must make a push into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst) !(w_push && w_fifo_full));

endmodule

// File: tb/tb_param_rom_stream_ctrl.sv
// Scoreboard bench for param_rom_stream_ctrl: expected words are queued when a
// command is issued and a monitor pops and compares every accepted beat.
module tb_param_rom_stream_ctrl;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH) + 1;
  localparam int LAT   = 2;
  localparam int FD    = 4;
  localparam int PW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [PW-1:0] cfg_passes = '0;
  logic          busy, done, rom_ce, last, valid;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_q, data_out;
  logic          ready = 1'b1;

  always #5 clk = ~clk;

  param_rom_stream_ctrl #(
    .DATA_WIDTH (DW), .DEPTH (DEPTH), .ADDR_WIDTH (AW),
    .ROM_LATENCY(LAT), .FIFO_DEPTH (FD), .PASS_WIDTH (PW)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_start          (start),
    .i_cfg_passes     (cfg_passes),
    .o_busy           (busy),
    .o_done           (done),
    .o_rom_addr       (rom_addr),
    .o_rom_ce         (rom_ce),
    .i_rom_q          (rom_q),
    .o_data_out       (data_out),
    .o_data_out_last  (last),
    .o_data_out_valid (valid),
    .i_data_out_ready (ready)
  );

  // ROM model: word = 0x100 + addr, two registered stages, clock-enable gated.
  logic [DW-1:0] rom_s1, rom_s2;
  always @(posedge clk) begin
    if (rom_ce) begin
      rom_s1 <= 16'h100 + 16'(rom_addr);
      rom_s2 <= rom_s1;
    end
  end
  assign rom_q = rom_s2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW:0] exp_q[$];

  int first_valid_cyc = -1;
  int last_pop_cyc    = -1;
  int start_cyc       = 0;
  int done_cnt        = 0;
  int done_cyc        = -1;
  bit done_busy, done_prev_busy, prev_busy, busy_seen;
  bit stall_prev = 1'b0;
  logic [DW:0] stall_word;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: every pass is the full tensor in address order, last on the final word.
  task automatic expect_passes(input int passes);
    for (int p = 0; p < passes; p++)
      for (int a = 0; a < DEPTH; a++)
        exp_q.push_back({(a == DEPTH - 1), 16'(16'h100 + a)});
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (busy) busy_seen = 1'b1;
      if (valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (stall_prev) begin
        check("stall_valid", 32'(valid), 1);
        check("stall_word", 32'({last, data_out}), 32'(stall_word));
      end
      stall_prev = valid && !ready;
      stall_word = {last, data_out};
      if (valid && ready) begin
        check("beat_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          check("beat_data", 32'(data_out), 32'(e[DW-1:0]));
          check("beat_last", 32'(last), 32'(e[DW]));
        end
        last_pop_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc       = cyc;
        done_busy      = busy;
        done_prev_busy = prev_busy;
      end
      prev_busy = busy;
    end
  end

  task automatic issue_start(input int passes);
    expect_passes(passes);
    first_valid_cyc = -1;
    busy_seen       = 1'b0;
    cfg_passes      = PW'(passes);
    start           = 1'b1;
    start_cyc       = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int passes, input bit rnd);
    int k = 0;
    while (done_cnt == d0 && k < 2000) begin
      ready = rnd ? ($urandom_range(0, 9) < 7) : 1'b1;
      tick();
      k++;
    end
    check("done_seen", 32'(done_cnt > d0), 1);
    ready = 1'b1;
    repeat (4) tick();
    check("single_done", 32'(done_cnt - d0), 1);
    check("all_beats_out", 32'(exp_q.size()), 0);
    check("busy_low_at_done", 32'(done_busy), 0);
    if (passes > 0) begin
      check("done_after_final_pop", 32'(done_cyc), 32'(last_pop_cyc + 1));
      check("busy_high_before_done", 32'(done_prev_busy), 1);
    end else begin
      check("zero_pass_done_latency", 32'(done_cyc), 32'(start_cyc + 1));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int d0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_valid", 32'(valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_rom_ce", 32'(rom_ce), 0);
    check("rst_rom_addr", 32'(rom_addr), 0);
    check("rst_data_out", 32'(data_out), 0);
    check("rst_last", 32'(last), 0);
    tick();
    rst = 1'b0;
    repeat (2) tick();

    // One pass, ready held high.
    d0 = done_cnt;
    issue_start(1);
    check("stream_busy", 32'(busy), 1);
    check("stream_rom_ce", 32'(rom_ce), 1);
    check("stream_first_addr", 32'(rom_addr), 0);
    wait_done(d0, 1, 1'b0);
    check("first_valid_latency", 32'(first_valid_cyc), 32'(start_cyc + 4));
    check("one_pass_back_to_back", 32'(last_pop_cyc - first_valid_cyc), 3);

    // Three passes, ready held high: 12 beats back to back.
    d0 = done_cnt;
    issue_start(3);
    wait_done(d0, 3, 1'b0);
    check("three_pass_back_to_back", 32'(last_pop_cyc - first_valid_cyc), 11);

    // Two passes with ready toggling and a long stall mid-pass.
    d0 = done_cnt;
    issue_start(2);
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      ready = (i % 2 == 0);
      tick();
    end
    ready = 1'b0;
    repeat (10) tick();
    wait_done(d0, 2, 1'b0);

    // Zero passes: done only, no beats, busy never rises.
    d0 = done_cnt;
    issue_start(0);
    wait_done(d0, 0, 1'b0);
    check("zero_pass_no_valid", 32'(first_valid_cyc), 32'hFFFF_FFFF);
    check("zero_pass_no_busy", 32'(busy_seen), 0);

    // Start while streaming is ignored.
    d0 = done_cnt;
    issue_start(1);
    tick();
    cfg_passes = PW'(5);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(d0, 1, 1'b0);

    // Reset with words held in the FIFO and in flight.
    ready = 1'b0;
    d0 = done_cnt;
    issue_start(1);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_valid", 32'(valid), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    repeat (5) tick();
    check("midrst_no_done", 32'(done_cnt - d0), 0);
    ready = 1'b1;
    d0 = done_cnt;
    issue_start(1);
    wait_done(d0, 1, 1'b0);
    check("post_rst_latency", 32'(first_valid_cyc), 32'(start_cyc + 4));

    // Randomized commands with random back-pressure.
    for (int n = 0; n < 8; n++) begin
      int p;
      p  = $urandom_range(1, 4);
      d0 = done_cnt;
      issue_start(p);
      wait_done(d0, p, 1'b1);
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
